// File: rtl/eth_resp_pkg.sv
// Shared types and constants for the Ethernet frame echo responder.
// Holds the responder state encoding and the MAC-address swap index mapping.
package eth_resp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RX   = 2'd1,
    ST_DROP = 2'd2,
    ST_TX   = 2'd3
  } state_t;

  localparam int MAC_ADDR_BYTES = 6;
  localparam int SWAP_SPAN      = 12;

  // Output byte i is read from buffer index swap_index(i): the first two
  // address fields trade places, everything after them is passed straight.
  function automatic int swap_index(input int i);
    if (i < MAC_ADDR_BYTES)  return i + MAC_ADDR_BYTES;
    else if (i < SWAP_SPAN)  return i - MAC_ADDR_BYTES;
    else                     return i;
  endfunction

endpackage

// File: rtl/eth_resp_frame_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port
// with read enable. 8 bits wide, 2^ADDR_WIDTH deep.
module eth_resp_frame_ram #(
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [7:0]            wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [7:0]            rdata
);

  logic [7:0] mem [2**ADDR_WIDTH];

  // NOTE: no reset on the storage array or read register, so this maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/eth_axis_frame_responder.sv
// Buffers each received frame whole, drops bad/runt/oversize frames and echoes
// good ones with MAC addresses swapped. Optional counters: ETH_RESP_STATS_EN.
module eth_axis_frame_responder
  import eth_resp_pkg::*;
#(
  parameter int ADDR_WIDTH       = 11,
  parameter int MIN_FRAME_LENGTH = 14
) (
  input  logic        logic_clk,
  input  logic        logic_rst,
  input  logic [7:0]  rx_axis_tdata,
  input  logic        rx_axis_tvalid,
  output logic        rx_axis_tready,
  input  logic        rx_axis_tlast,
  input  logic        rx_axis_tuser,
  output logic [7:0]  tx_axis_tdata,
  output logic        tx_axis_tvalid,
  input  logic        tx_axis_tready,
  output logic        tx_axis_tlast,
  output logic        tx_axis_tuser,
  output logic        frame_done,
  output logic        frame_drop,
  output logic        busy,
  output logic [31:0] good_count,
  output logic [31:0] drop_count
);

  localparam int LW = ADDR_WIDTH + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(2**ADDR_WIDTH);
  localparam logic [LW:0]   DEPTH_X = (LW+1)'(2**ADDR_WIDTH);
  localparam logic [LW:0]   MIN_X   = (LW+1)'(MIN_FRAME_LENGTH);

  state_t          state_q, state_nxt;
  logic [LW-1:0]   len_q, tx_len_q, rd_idx_q, rd_idx_cur;
  logic [LW:0]     frame_len;
  logic            rdy_q, rx_acc, in_rx, frame_good;
  logic            start_tx, drop_evt, done_evt, tx_issue, rd_en, rd_last;
  logic            rd_vld_q, rd_last_q, pop;
  logic [ADDR_WIDTH-1:0] ram_raddr;
  logic [7:0]      ram_rdata;
  logic [8:0]      fifo_q [2];
  logic            wr_ptr_q, rd_ptr_q;
  logic [1:0]      cnt_q;
  logic [2:0]      occ;

  assign rx_axis_tready = rdy_q;
  assign rx_acc         = rx_axis_tvalid & rdy_q;
  assign in_rx          = (state_q == ST_IDLE) || (state_q == ST_RX);
  assign frame_len      = {1'b0, len_q} + (LW+1)'(1);
  assign frame_good     = !rx_axis_tuser && (frame_len >= MIN_X) && (frame_len <= DEPTH_X);
  assign start_tx       = rx_acc & rx_axis_tlast & in_rx & frame_good;
  assign drop_evt       = rx_acc & rx_axis_tlast & ((in_rx & ~frame_good) | (state_q == ST_DROP));

  // Two-entry output stage; head entry drives the tx port directly so it holds under stall.
  assign tx_axis_tvalid = (cnt_q != 2'd0);
  assign {tx_axis_tlast, tx_axis_tdata} = fifo_q[rd_ptr_q];
  assign tx_axis_tuser  = 1'b0;
  assign pop            = tx_axis_tvalid & tx_axis_tready;
  assign done_evt       = pop & tx_axis_tlast;
  assign busy           = (state_q != ST_IDLE);

  // Reads in flight plus stored entries must never exceed the two slots.
  assign occ        = {1'b0, cnt_q} + {2'b00, rd_vld_q} - {2'b00, pop};
  assign tx_issue   = (state_q == ST_TX) && (rd_idx_q < tx_len_q) && (occ < 3'd2);
  assign rd_en      = start_tx | tx_issue;
  assign rd_idx_cur = start_tx ? '0 : rd_idx_q;
  assign rd_last    = ({1'b0, rd_idx_cur} + (LW+1)'(1)) == (start_tx ? frame_len : {1'b0, tx_len_q});
  assign ram_raddr  = ADDR_WIDTH'(swap_index(int'(rd_idx_cur)));

  eth_resp_frame_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk   (logic_clk),
    .we    (rx_acc && in_rx && (len_q < DEPTH_L)),
    .waddr (len_q[ADDR_WIDTH-1:0]),
    .wdata (rx_axis_tdata),
    .re    (rd_en),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // NOTE: every variable gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE, ST_RX: begin
        if (rx_acc) begin
          if (rx_axis_tlast)          state_nxt = frame_good ? ST_TX : ST_IDLE;
          else if (len_q == DEPTH_L)  state_nxt = ST_DROP;
          else                        state_nxt = ST_RX;
        end
      end
      ST_DROP: if (rx_acc && rx_axis_tlast) state_nxt = ST_IDLE;
      ST_TX:   if (done_evt)                state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge logic_clk) begin
    if (logic_rst) begin
      state_q    <= ST_IDLE;
      rdy_q      <= 1'b0;
      len_q      <= '0;
      tx_len_q   <= '0;
      rd_idx_q   <= '0;
      rd_vld_q   <= 1'b0;
      rd_last_q  <= 1'b0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
      frame_done <= 1'b0;
      frame_drop <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      rdy_q      <= (state_nxt != ST_TX);
      frame_done <= done_evt;
      frame_drop <= drop_evt;

      if (state_nxt == ST_IDLE)                        len_q <= '0;
      else if (rx_acc && in_rx && (len_q != DEPTH_L))  len_q <= len_q + LW'(1);

      if (start_tx) begin
        tx_len_q <= frame_len[LW-1:0];
        rd_idx_q <= LW'(1);
      end else if (tx_issue) begin
        rd_idx_q <= rd_idx_q + LW'(1);
      end

      rd_vld_q  <= rd_en;
      rd_last_q <= rd_last;
      if (rd_vld_q) begin
        fifo_q[wr_ptr_q] <= {rd_last_q, ram_rdata};
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, rd_vld_q} - {1'b0, pop};
    end
  end

`ifdef ETH_RESP_STATS_EN
  always_ff @(posedge logic_clk) begin
    if (logic_rst) begin
      good_count <= '0;
      drop_count <= '0;
    end else begin
      if (frame_done) good_count <= good_count + 32'd1;
      if (frame_drop) drop_count <= drop_count + 32'd1;
    end
  end
`else
  assign good_count = '0;
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_eth_axis_frame_responder.sv
// Self-checking bench for eth_axis_frame_responder: directed plus random frames
// compared against a frame-level echo model; honours ETH_RESP_STATS_EN.
module tb_eth_axis_frame_responder;

  localparam int AW    = 8;
  localparam int DEPTH = 2**AW;
  localparam int MINL  = 14;
  localparam int BOUND = 6000;
`ifdef ETH_RESP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        logic_clk = 1'b0;
  logic        logic_rst;
  logic [7:0]  rx_axis_tdata;
  logic        rx_axis_tvalid, rx_axis_tready, rx_axis_tlast, rx_axis_tuser;
  logic [7:0]  tx_axis_tdata;
  logic        tx_axis_tvalid, tx_axis_tready, tx_axis_tlast, tx_axis_tuser;
  logic        frame_done, frame_drop, busy;
  logic [31:0] good_count, drop_count;

  eth_axis_frame_responder #(.ADDR_WIDTH(AW), .MIN_FRAME_LENGTH(MINL)) dut (
    .logic_clk(logic_clk), .logic_rst(logic_rst),
    .rx_axis_tdata(rx_axis_tdata), .rx_axis_tvalid(rx_axis_tvalid),
    .rx_axis_tready(rx_axis_tready), .rx_axis_tlast(rx_axis_tlast),
    .rx_axis_tuser(rx_axis_tuser),
    .tx_axis_tdata(tx_axis_tdata), .tx_axis_tvalid(tx_axis_tvalid),
    .tx_axis_tready(tx_axis_tready), .tx_axis_tlast(tx_axis_tlast),
    .tx_axis_tuser(tx_axis_tuser),
    .frame_done(frame_done), .frame_drop(frame_drop), .busy(busy),
    .good_count(good_count), .drop_count(drop_count)
  );

  always #5 logic_clk = ~logic_clk;

  int unsigned cyc = 0;
  always @(posedge logic_clk) cyc <= cyc + 1;

  // tx_axis_tready pattern: 0 = always high, 1 = 1,0,0,1 repeating, 2 = random
  int rdy_mode = 0;
  initial begin
    int ph = 0;
    tx_axis_tready = 1'b0;
    forever begin
      @(posedge logic_clk); #1;
      case (rdy_mode)
        1:       begin tx_axis_tready = !(ph == 1 || ph == 2); ph = (ph + 1) % 4; end
        2:       tx_axis_tready = ($urandom_range(0, 3) != 0);
        default: tx_axis_tready = 1'b1;
      endcase
    end
  end

  // Monitor: collects the echoed stream and protocol observations.
  logic [8:0]  obs_q[$];
  int unsigned last_tlast_cyc = 0, first_valid_cyc = 0, last_hs_cyc = 0;
  int unsigned done_cyc = 0, drop_cyc = 0;
  int          done_pulses = 0, drop_pulses = 0;
  int          done_idle_viol = 0, txrx_viol = 0, stab_viol = 0;
  logic        prev_tvalid = 1'b0, hold_pend = 1'b0;
  logic [8:0]  held = '0;

  always @(negedge logic_clk) begin
    if (rx_axis_tvalid && rx_axis_tready && rx_axis_tlast) last_tlast_cyc <= cyc;
    if (tx_axis_tvalid && !prev_tvalid) first_valid_cyc <= cyc;
    prev_tvalid <= tx_axis_tvalid;
    if (tx_axis_tvalid && tx_axis_tready) begin
      obs_q.push_back({tx_axis_tlast, tx_axis_tdata});
      if (tx_axis_tlast) last_hs_cyc <= cyc;
    end
    if (frame_done) begin
      done_pulses <= done_pulses + 1;
      done_cyc    <= cyc;
      if (busy || !rx_axis_tready) done_idle_viol <= done_idle_viol + 1;
    end
    if (frame_drop) begin
      drop_pulses <= drop_pulses + 1;
      drop_cyc    <= cyc;
    end
    if (busy && tx_axis_tvalid && rx_axis_tready) txrx_viol <= txrx_viol + 1;
    if (hold_pend && (!tx_axis_tvalid || {tx_axis_tlast, tx_axis_tdata} != held))
      stab_viol <= stab_viol + 1;
    hold_pend <= tx_axis_tvalid && !tx_axis_tready;
    held      <= {tx_axis_tlast, tx_axis_tdata};
  end

  // Reference model state
  logic [7:0] frm[$];
  logic [8:0] exp_q[$];
  int tests = 0, fails = 0;
  int tot_good = 0, tot_drop = 0, stat_good = 0, stat_drop = 0;
  int cmp_idx = 0, stall_cycles = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int stat_exp(input int v);
    return STATS ? v : 0;
  endfunction

  task automatic make_frame(input int n);
    frm.delete();
    for (int i = 0; i < n; i++) frm.push_back(8'($urandom));
  endtask

  // Echo model: a good frame comes back with its two 6-byte address fields swapped.
  task automatic model_frame(input bit bad);
    int n = frm.size();
    logic [7:0] o[$];
    if (!bad && n >= MINL && n <= DEPTH) begin
      for (int k = 6; k < 12; k++) o.push_back(frm[k]);
      for (int k = 0; k < 6; k++)  o.push_back(frm[k]);
      for (int k = 12; k < n; k++) o.push_back(frm[k]);
      for (int k = 0; k < n; k++)  exp_q.push_back({k == n - 1, o[k]});
      tot_good++; stat_good++;
    end else begin
      tot_drop++; stat_drop++;
    end
  endtask

  // Sends nsend bytes of frm; a full frame carries tlast and updates the model.
  task automatic send_frame(input bit bad, input int gap_max, input int nsend);
    int  n    = frm.size();
    bit  full = (nsend >= n);
    int  cnt  = full ? n : nsend;
    stall_cycles = 0;
    for (int i = 0; i < cnt; i++) begin
      int w = 0;
      int g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      if (g > 0) begin
        rx_axis_tvalid = 1'b0;
        repeat (g) @(posedge logic_clk);
        #1;
      end
      rx_axis_tdata  = frm[i];
      rx_axis_tvalid = 1'b1;
      rx_axis_tlast  = full && (i == n - 1);
      rx_axis_tuser  = (full && i == n - 1) ? bad : 1'($urandom_range(0, 1));
      @(negedge logic_clk);
      while (!rx_axis_tready && w < BOUND) begin
        w++;
        @(negedge logic_clk);
      end
      if (w >= BOUND) begin
        fails++;
        $display("FAIL rx_accept_timeout: byte %0d not accepted within %0d cycles", i, BOUND);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "rx handshake timeout");
      end
      stall_cycles += w;
      @(posedge logic_clk); #1;
    end
    rx_axis_tvalid = 1'b0;
    rx_axis_tlast  = 1'b0;
    rx_axis_tuser  = 1'b0;
    if (full) model_frame(bad);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge logic_clk);
    while ((busy || tx_axis_tvalid || obs_q.size() < exp_q.size()) && n < BOUND) begin
      @(negedge logic_clk);
      n++;
    end
    check({tag, "_drain"}, 32'(n < BOUND), 32'd1);
    repeat (3) @(negedge logic_clk);
    @(posedge logic_clk); #1;
  endtask

  task automatic compare_stream(input string tag);
    int mism = 0;
    check({tag, "_len"}, obs_q.size(), exp_q.size());
    for (int k = cmp_idx; k < exp_q.size(); k++)
      if (k >= obs_q.size() || obs_q[k] !== exp_q[k]) mism++;
    check({tag, "_bytes"}, mism, 0);
    cmp_idx = exp_q.size();
  endtask

  initial begin
    int base, d0, p0;
    logic_rst = 1'b1;
    rx_axis_tdata = '0; rx_axis_tvalid = 1'b0; rx_axis_tlast = 1'b0; rx_axis_tuser = 1'b0;
    repeat (3) @(posedge logic_clk);
    @(negedge logic_clk);
    check("rst_rx_tready", 32'(rx_axis_tready), 0);
    check("rst_tx_tvalid", 32'(tx_axis_tvalid), 0);
    check("rst_tx_tdata",  32'(tx_axis_tdata), 0);
    check("rst_tx_tlast",  32'(tx_axis_tlast), 0);
    check("rst_tx_tuser",  32'(tx_axis_tuser), 0);
    check("rst_done",      32'(frame_done), 0);
    check("rst_drop",      32'(frame_drop), 0);
    check("rst_busy",      32'(busy), 0);
    check("rst_good_cnt",  good_count, 0);
    check("rst_drop_cnt",  drop_count, 0);
    @(posedge logic_clk); #1;
    logic_rst = 1'b0;

    // 64-byte frame with fixed addresses, tready held high
    make_frame(64);
    for (int k = 0; k < 6; k++) begin
      frm[k]     = (k == 0) ? 8'h02 : (k == 5) ? 8'h01 : 8'h00;
      frm[k + 6] = (k == 0) ? 8'h02 : (k == 5) ? 8'h02 : 8'h00;
    end
    base = cmp_idx; d0 = done_pulses;
    send_frame(1'b0, 0, 64);
    wait_idle("t1");
    check("t1_latency", first_valid_cyc - last_tlast_cyc, 2);
    check("t1_done_once", done_pulses - d0, 1);
    check("t1_done_timing", done_cyc - last_hs_cyc, 1);
    check("t1_out0", 32'(obs_q[base]), 32'h002);
    check("t1_out5", 32'(obs_q[base + 5]), 32'h002);
    check("t1_out6", 32'(obs_q[base + 6]), 32'h002);
    check("t1_out11", 32'(obs_q[base + 11]), 32'h001);
    check("t1_out63_last", 32'(obs_q[base + 63][8]), 1);
    compare_stream("t1");
    check("t1_good_cnt", good_count, stat_exp(stat_good));

    // 64-byte frame flagged bad on tlast
    make_frame(64);
    p0 = drop_pulses;
    send_frame(1'b1, 0, 64);
    wait_idle("t2");
    check("t2_drop_once", drop_pulses - p0, 1);
    check("t2_drop_timing", drop_cyc - last_tlast_cyc, 1);
    compare_stream("t2");
    check("t2_drop_cnt", drop_count, stat_exp(stat_drop));

    // runt, max-size, and one-over-max frames
    make_frame(10);
    p0 = drop_pulses;
    send_frame(1'b0, 0, 10);
    wait_idle("t3a");
    check("t3a_runt_drop", drop_pulses - p0, 1);
    make_frame(DEPTH);
    send_frame(1'b0, 0, DEPTH);
    wait_idle("t3b");
    compare_stream("t3b");
    make_frame(DEPTH + 1);
    p0 = drop_pulses;
    send_frame(1'b0, 0, DEPTH + 1);
    check("t3c_no_rx_stall", stall_cycles, 0);
    wait_idle("t3c");
    check("t3c_over_drop", drop_pulses - p0, 1);
    compare_stream("t3c");

    // 100-byte echo under a 1,0,0,1 tready pattern
    rdy_mode = 1;
    make_frame(100);
    send_frame(1'b0, 0, 100);
    wait_idle("t4");
    compare_stream("t4");
    check("t4_hold_stable", stab_viol, 0);
    check("t4_rx_tready_low_in_tx", txrx_viol, 0);
    rdy_mode = 0;

    // reset mid-frame, then a fresh 60-byte frame
    make_frame(64);
    p0 = drop_pulses; d0 = done_pulses;
    send_frame(1'b0, 0, 30);
    logic_rst = 1'b1;
    @(posedge logic_clk); #1;
    logic_rst = 1'b0;
    stat_good = 0; stat_drop = 0;
    @(negedge logic_clk);
    check("t5_busy_after_rst", 32'(busy), 0);
    check("t5_good_cnt0", good_count, 0);
    check("t5_drop_cnt0", drop_count, 0);
    @(posedge logic_clk); #1;
    make_frame(60);
    send_frame(1'b0, 0, 60);
    wait_idle("t5");
    compare_stream("t5");
    check("t5_no_drop", drop_pulses - p0, 0);
    check("t5_one_done", done_pulses - d0, 1);
    check("t5_good_cnt1", good_count, stat_exp(stat_good));

    // two 64-byte frames back-to-back with tvalid held high
    make_frame(64);
    send_frame(1'b0, 0, 64);
    make_frame(64);
    send_frame(1'b0, 0, 64);
    wait_idle("t6");
    compare_stream("t6");
    check("t6_good_cnt", good_count, stat_exp(stat_good));

    // random frames, lengths around every boundary, random tready and gaps
    rdy_mode = 2;
    for (int r = 0; r < 10; r++) begin
      int sel = int'($urandom_range(0, 5));
      int n;
      bit bad = ($urandom_range(0, 4) == 0);
      case (sel)
        0:       n = int'($urandom_range(1, MINL - 1));
        1:       n = DEPTH;
        2:       n = DEPTH + 1;
        3:       n = DEPTH + 2;
        default: n = int'($urandom_range(MINL, 120));
      endcase
      make_frame(n);
      send_frame(bad, (r % 2) * 2, n);
      wait_idle("rnd");
      compare_stream("rnd");
    end
    rdy_mode = 0;

    check("final_done_pulses", done_pulses, tot_good);
    check("final_drop_pulses", drop_pulses, tot_drop);
    check("final_good_cnt", good_count, stat_exp(stat_good));
    check("final_drop_cnt", drop_count, stat_exp(stat_drop));
    check("final_hold_stable", stab_viol, 0);
    check("final_rx_tready_tx", txrx_viol, 0);
    check("final_done_idle", done_idle_viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
